// File: rtl/color_centroid.sv
// color_centroid: classifies RGB pixels against min/max windows and reports the matched-pixel centroid per frame.
// Latency: RESULT_VALID pulses 2*SUM_W+2 cycles after the frame-end pixel is sampled (56 at defaults). It does not depend on the data.
// Backpressure: none. A frame that ends while the divider is busy is discarded and flagged on FRAME_DROP.
// Optional bounding-box outputs are enabled by defining COLOR_CENTROID_BBOX_EN.
module color_centroid #(
   parameter int  WIDTH      = 640,
   parameter int  HEIGHT     = 480,
   parameter int  R_W        = 5,
   parameter int  G_W        = 6,
   parameter int  B_W        = 5,
   parameter int  MIN_PIXELS = 16,
   localparam int COL_W      = $clog2(WIDTH),
   localparam int ROW_W      = $clog2(HEIGHT),
   localparam int CNT_W      = $clog2(WIDTH*HEIGHT+1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [R_W-1:0]   RED,
   input  logic [G_W-1:0]   GREEN,
   input  logic [B_W-1:0]   BLUE,
   input  logic [ROW_W-1:0] PIXEL_ROW,
   input  logic [COL_W-1:0] PIXEL_COLUMN,
   input  logic             READY_COLOR,
   input  logic [R_W-1:0]   R_MIN,
   input  logic [R_W-1:0]   R_MAX,
   input  logic [G_W-1:0]   G_MIN,
   input  logic [G_W-1:0]   G_MAX,
   input  logic [B_W-1:0]   B_MIN,
   input  logic [B_W-1:0]   B_MAX,
   output logic [CNT_W-1:0] PIXEL_COUNT,
   output logic [COL_W-1:0] CENTROID_X,
   output logic [ROW_W-1:0] CENTROID_Y,
   output logic             DETECTED,
   output logic             RESULT_VALID,
   output logic             BUSY,
   output logic             FRAME_DROP
`ifdef COLOR_CENTROID_BBOX_EN
   ,
   output logic [COL_W-1:0] BBOX_XMIN,
   output logic [COL_W-1:0] BBOX_XMAX,
   output logic [ROW_W-1:0] BBOX_YMIN,
   output logic [ROW_W-1:0] BBOX_YMAX
`endif
);

   // Sum width covers a frame in which every pixel matches.
   localparam longint SX_MAX = longint'(HEIGHT) * longint'(WIDTH) * longint'(WIDTH-1) / 2;
   localparam longint SY_MAX = longint'(WIDTH) * longint'(HEIGHT) * longint'(HEIGHT-1) / 2;
   localparam int     SUM_W  = $clog2(((SX_MAX > SY_MAX) ? SX_MAX : SY_MAX) + 1);
   localparam int     IT_W   = $clog2(SUM_W);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH-1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT-1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
   localparam logic [IT_W-1:0]  LAST_IT  = IT_W'(SUM_W-1);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t             state_q, state_nx;
   logic               busy, div_run, div_last;

   logic               ready_d;
   logic               pix_stb;
   logic               color_match;

   // Registered pixel stage. Classification happens on the strobe cycle, and accumulation happens one cycle later.
   logic               s1_vld, s1_match, s1_end;
   logic [COL_W-1:0]   s1_col;
   logic [ROW_W-1:0]   s1_row;
   logic               take, frame_end;

   logic [CNT_W-1:0]   cnt_q, cnt_upd, snap_cnt;
   logic [SUM_W-1:0]   sumx_q, sumx_upd, sumy_q, sumy_upd, snap_sumy;

   logic [CNT_W-1:0]   rem_q, rem_nx;
   logic [CNT_W:0]     rem_sh;
   logic               sub_ok;
   logic [SUM_W-1:0]   quo_q, quo_nx;
   logic [IT_W-1:0]    it_q;
   logic [COL_W-1:0]   qx_q;

`ifdef COLOR_CENTROID_BBOX_EN
   logic [COL_W-1:0]   xmin_q, xmax_q, xmin_upd, xmax_upd, snap_xmin, snap_xmax;
   logic [ROW_W-1:0]   ymin_q, ymax_q, ymin_upd, ymax_upd, snap_ymin, snap_ymax;
`endif

   assign pix_stb     = READY_COLOR & ~ready_d;
   // An inverted window (MIN > MAX) cannot be satisfied, so it matches nothing.
   assign color_match = (RED   >= R_MIN) && (RED   <= R_MAX) &&
                        (GREEN >= G_MIN) && (GREEN <= G_MAX) &&
                        (BLUE  >= B_MIN) && (BLUE  <= B_MAX);

   // Edge-detect READY_COLOR and register the classified pixel.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ready_d  <= 1'b1;
         s1_vld   <= 1'b0;
         s1_match <= 1'b0;
         s1_end   <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         ready_d  <= READY_COLOR;
         s1_vld   <= pix_stb;
         s1_match <= color_match;
         s1_end   <= (PIXEL_ROW == LAST_ROW) && (PIXEL_COLUMN == LAST_COL);
         s1_col   <= PIXEL_COLUMN;
         s1_row   <= PIXEL_ROW;
      end
   end

   assign take      = s1_vld & s1_match;
   assign frame_end = s1_vld & s1_end;
   assign cnt_upd   = take ? cnt_q + CNT_W'(1) : cnt_q;
   assign sumx_upd  = take ? sumx_q + SUM_W'(s1_col) : sumx_q;
   assign sumy_upd  = take ? sumy_q + SUM_W'(s1_row) : sumy_q;

`ifdef COLOR_CENTROID_BBOX_EN
   assign xmin_upd = (take && s1_col < xmin_q) ? s1_col : xmin_q;
   assign xmax_upd = (take && s1_col > xmax_q) ? s1_col : xmax_q;
   assign ymin_upd = (take && s1_row < ymin_q) ? s1_row : ymin_q;
   assign ymax_upd = (take && s1_row > ymax_q) ? s1_row : ymax_q;
`endif

   // Per-frame accumulators. They restart on the frame-end edge, and the frame-end pixel is folded into the snapshot.
   always_ff @(posedge CLK) begin
      if (RST || frame_end) begin
         cnt_q  <= '0;
         sumx_q <= '0;
         sumy_q <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
         xmin_q <= '1;
         xmax_q <= '0;
         ymin_q <= '1;
         ymax_q <= '0;
`endif
      end else begin
         cnt_q  <= cnt_upd;
         sumx_q <= sumx_upd;
         sumy_q <= sumy_upd;
`ifdef COLOR_CENTROID_BBOX_EN
         xmin_q <= xmin_upd;
         xmax_q <= xmax_upd;
         ymin_q <= ymin_upd;
         ymax_q <= ymax_upd;
`endif
      end
   end

   // Snapshot the totals of an accepted frame and flag frames that end while the divider is busy.
   always_ff @(posedge CLK) begin
      if (RST) begin
         snap_cnt   <= '0;
         snap_sumy  <= '0;
         FRAME_DROP <= 1'b0;
`ifdef COLOR_CENTROID_BBOX_EN
         snap_xmin  <= '0;
         snap_xmax  <= '0;
         snap_ymin  <= '0;
         snap_ymax  <= '0;
`endif
      end else begin
         FRAME_DROP <= frame_end & busy;
         if (frame_end && !busy) begin
            snap_cnt  <= cnt_upd;
            snap_sumy <= sumy_upd;
`ifdef COLOR_CENTROID_BBOX_EN
            snap_xmin <= xmin_upd;
            snap_xmax <= xmax_upd;
            snap_ymin <= ymin_upd;
            snap_ymax <= ymax_upd;
`endif
         end
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   // Next-state logic. Each divide phase runs exactly SUM_W iterations.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (frame_end) state_nx = DIV_X;
         DIV_X:   if (it_q == LAST_IT) state_nx = DIV_Y;
         DIV_Y:   if (it_q == LAST_IT) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM decoded outputs.
   always_comb begin
      busy     = (state_q != IDLE);
      div_run  = (state_q == DIV_X) || (state_q == DIV_Y);
      div_last = div_run && (it_q == LAST_IT);
   end

   assign BUSY = busy;

   // One restoring step: shift in the next dividend bit and subtract the count if it fits.
   always_comb begin
      rem_sh = {rem_q, quo_q[SUM_W-1]};
      sub_ok = (rem_sh >= {1'b0, snap_cnt});
      rem_nx = sub_ok ? CNT_W'(rem_sh - {1'b0, snap_cnt}) : rem_sh[CNT_W-1:0];
      quo_nx = {quo_q[SUM_W-2:0], sub_ok};
   end

   // Divider datapath. sumx is loaded at frame acceptance, and sumy is loaded when the X phase ends.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rem_q <= '0;
         quo_q <= '0;
         it_q  <= '0;
         qx_q  <= '0;
      end else if (state_q == IDLE) begin
         if (frame_end) begin
            quo_q <= sumx_upd;
            rem_q <= '0;
            it_q  <= '0;
         end
      end else if (div_run) begin
         if (div_last) begin
            it_q  <= '0;
            rem_q <= '0;
            if (state_q == DIV_X) begin
               qx_q  <= quo_nx[COL_W-1:0];
               quo_q <= snap_sumy;
            end else begin
               quo_q <= quo_nx;
            end
         end else begin
            it_q  <= it_q + IT_W'(1);
            rem_q <= rem_nx;
            quo_q <= quo_nx;
         end
      end
   end

   // Publish results in DONE. Outputs hold their values until the next DONE, and an empty frame reports zeros.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RESULT_VALID <= 1'b0;
         PIXEL_COUNT  <= '0;
         CENTROID_X   <= '0;
         CENTROID_Y   <= '0;
         DETECTED     <= 1'b0;
`ifdef COLOR_CENTROID_BBOX_EN
         BBOX_XMIN    <= '0;
         BBOX_XMAX    <= '0;
         BBOX_YMIN    <= '0;
         BBOX_YMAX    <= '0;
`endif
      end else begin
         RESULT_VALID <= (state_q == DONE);
         if (state_q == DONE) begin
            PIXEL_COUNT <= snap_cnt;
            DETECTED    <= (snap_cnt != '0) && (snap_cnt >= MIN_CNT);
            if (snap_cnt == '0) begin
               CENTROID_X <= '0;
               CENTROID_Y <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
               BBOX_XMIN  <= '0;
               BBOX_XMAX  <= '0;
               BBOX_YMIN  <= '0;
               BBOX_YMAX  <= '0;
`endif
            end else begin
               CENTROID_X <= qx_q;
               CENTROID_Y <= quo_q[ROW_W-1:0];
`ifdef COLOR_CENTROID_BBOX_EN
               BBOX_XMIN  <= snap_xmin;
               BBOX_XMAX  <= snap_xmax;
               BBOX_YMIN  <= snap_ymin;
               BBOX_YMAX  <= snap_ymax;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_color_centroid.sv
// tb_color_centroid: directed frames for color_centroid at default parameters, checked against a frame-level model.
// Latency: results are expected 56 cycles after each accepted frame-end strobe.
// Backpressure: frames ending inside that window are expected to be dropped.
module tb_color_centroid;
   localparam int WIDTH = 640;
   localparam int HEIGHT = 480;
   localparam int MIN_PIXELS = 16;
   localparam int COL_W = 10;
   localparam int ROW_W = 9;
   localparam int CNT_W = 19;
   localparam int LAT = 56;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [4:0]       RED = '0;
   logic [5:0]       GREEN = '0;
   logic [4:0]       BLUE = '0;
   logic [ROW_W-1:0] PIXEL_ROW = '0;
   logic [COL_W-1:0] PIXEL_COLUMN = '0;
   logic             READY_COLOR = 1'b1;
   logic [4:0]       R_MIN = '0, R_MAX = '0;
   logic [5:0]       G_MIN = '0, G_MAX = '0;
   logic [4:0]       B_MIN = '0, B_MAX = '0;
   logic [CNT_W-1:0] PIXEL_COUNT;
   logic [COL_W-1:0] CENTROID_X;
   logic [ROW_W-1:0] CENTROID_Y;
   logic             DETECTED, RESULT_VALID, BUSY, FRAME_DROP;
`ifdef COLOR_CENTROID_BBOX_EN
   logic [COL_W-1:0] BBOX_XMIN, BBOX_XMAX;
   logic [ROW_W-1:0] BBOX_YMIN, BBOX_YMAX;
`endif

   color_centroid dut (
      .CLK(CLK), .RST(RST), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .PIXEL_ROW(PIXEL_ROW), .PIXEL_COLUMN(PIXEL_COLUMN), .READY_COLOR(READY_COLOR),
      .R_MIN(R_MIN), .R_MAX(R_MAX), .G_MIN(G_MIN), .G_MAX(G_MAX), .B_MIN(B_MIN), .B_MAX(B_MAX),
      .PIXEL_COUNT(PIXEL_COUNT), .CENTROID_X(CENTROID_X), .CENTROID_Y(CENTROID_Y),
      .DETECTED(DETECTED), .RESULT_VALID(RESULT_VALID), .BUSY(BUSY), .FRAME_DROP(FRAME_DROP)
`ifdef COLOR_CENTROID_BBOX_EN
      , .BBOX_XMIN(BBOX_XMIN), .BBOX_XMAX(BBOX_XMAX), .BBOX_YMIN(BBOX_YMIN), .BBOX_YMAX(BBOX_YMAX)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail = 0;

   // Frame-level model: running totals, published-result queue, busy window.
   typedef struct {
      int due; int cnt; int cx; int cy; int det;
      int xmin; int xmax; int ymin; int ymax;
   } res_t;

   res_t pend[$];
   res_t cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   int   m_cnt = 0, m_sx = 0, m_sy = 0;
   int   m_xmin = 1023, m_xmax = 0, m_ymin = 511, m_ymax = 0;
   bit   acc_vld = 1'b0;
   int   acc_t = 0;
   int   drops_exp = 0, drops_seen = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear_running();
      m_cnt = 0; m_sx = 0; m_sy = 0;
      m_xmin = 1023; m_xmax = 0; m_ymin = 511; m_ymax = 0;
   endtask

   task automatic model_frame_end(input int t);
      res_t r;
      if (acc_vld && (t - acc_t) < LAT) begin
         drops_exp++;
      end else begin
         r.due  = t + LAT;
         r.cnt  = m_cnt;
         r.cx   = (m_cnt == 0) ? 0 : (m_sx / m_cnt) % (1 << COL_W);
         r.cy   = (m_cnt == 0) ? 0 : (m_sy / m_cnt) % (1 << ROW_W);
         r.det  = (m_cnt != 0 && m_cnt >= MIN_PIXELS) ? 1 : 0;
         r.xmin = (m_cnt == 0) ? 0 : m_xmin;
         r.xmax = (m_cnt == 0) ? 0 : m_xmax;
         r.ymin = (m_cnt == 0) ? 0 : m_ymin;
         r.ymax = (m_cnt == 0) ? 0 : m_ymax;
         pend.push_back(r);
         acc_vld = 1'b1;
         acc_t = t;
      end
      model_clear_running();
   endtask

   // Send one pixel: a rising edge of READY_COLOR, then drop it the next cycle.
   task automatic pix(input int col, input int row, input int r, input int g, input int b);
      bit m;
      @(negedge CLK);
      PIXEL_COLUMN = COL_W'(col);
      PIXEL_ROW    = ROW_W'(row);
      RED          = 5'(r);
      GREEN        = 6'(g);
      BLUE         = 5'(b);
      READY_COLOR  = 1'b1;
      @(negedge CLK);
      READY_COLOR  = 1'b0;
      m = (r >= int'(R_MIN)) && (r <= int'(R_MAX)) && (g >= int'(G_MIN)) && (g <= int'(G_MAX)) &&
          (b >= int'(B_MIN)) && (b <= int'(B_MAX));
      if (m) begin
         m_cnt++; m_sx += col; m_sy += row;
         if (col < m_xmin) m_xmin = col;
         if (col > m_xmax) m_xmax = col;
         if (row < m_ymin) m_ymin = row;
         if (row > m_ymax) m_ymax = row;
      end
      if (col == WIDTH-1 && row == HEIGHT-1) model_frame_end(cyc);
   endtask

   task automatic set_win(input int rmin, input int rmax, input int gmin, input int gmax,
                          input int bmin, input int bmax);
      @(negedge CLK);
      R_MIN = 5'(rmin); R_MAX = 5'(rmax);
      G_MIN = 6'(gmin); G_MAX = 6'(gmax);
      B_MIN = 5'(bmin); B_MAX = 5'(bmax);
   endtask

   task automatic wait_rv(input string tag);
      int n;
      n = 0;
      while (!RESULT_VALID && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!RESULT_VALID) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: no RESULT_VALID within 200 cycles", tag);
      end else begin
         check({tag, "_latency"}, cyc - acc_t, LAT);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      pend.delete();
      cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      acc_vld = 1'b0;
      model_clear_running();
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      bit exp_rv;
      forever begin
         @(posedge CLK);
         #1;
         if (cyc >= 1) begin
            exp_rv = (pend.size() > 0 && pend[0].due == cyc);
            if (exp_rv) cur = pend.pop_front();
            check("result_valid", RESULT_VALID, exp_rv);
            check("pixel_count", PIXEL_COUNT, cur.cnt);
            check("centroid_x", CENTROID_X, cur.cx);
            check("centroid_y", CENTROID_Y, cur.cy);
            check("detected", DETECTED, cur.det);
`ifdef COLOR_CENTROID_BBOX_EN
            check("bbox_xmin", BBOX_XMIN, cur.xmin);
            check("bbox_xmax", BBOX_XMAX, cur.xmax);
            check("bbox_ymin", BBOX_YMIN, cur.ymin);
            check("bbox_ymax", BBOX_YMAX, cur.ymax);
`endif
            if (FRAME_DROP) drops_seen++;
            if (acc_vld && cyc >= acc_t + 2 && cyc <= acc_t + 54) check("busy_high", BUSY, 1);
            else if (!acc_vld || cyc > acc_t + 57) check("busy_low", BUSY, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with READY_COLOR high on a matching frame-end pixel: no strobe may follow release.
      R_MIN = 5'd25; R_MAX = 5'd31; G_MIN = 6'd0; G_MAX = 6'd5; B_MIN = 5'd0; B_MAX = 5'd5;
      RED = 5'd28; GREEN = 6'd2; BLUE = 5'd2;
      PIXEL_COLUMN = COL_W'(WIDTH-1); PIXEL_ROW = ROW_W'(HEIGHT-1);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      READY_COLOR = 1'b0;
      repeat (70) @(negedge CLK);
      check("reset_count", PIXEL_COUNT, 0);

      // 10x10 block at cols 100..109, rows 50..59, with near-miss pixels around it.
      for (int row = 50; row < 60; row++) begin
         pix(99, row, 24, 2, 2);
         for (int col = 100; col < 110; col++) pix(col, row, 28, 2, 2);
         pix(110, row, 28, 6, 2);
         pix(111, row, 28, 2, 6);
      end
      pix(639, 479, 0, 0, 0);
      wait_rv("block");
      check("block_count", PIXEL_COUNT, 100);
      check("block_cx", CENTROID_X, 104);
      check("block_cy", CENTROID_Y, 54);
      check("block_det", DETECTED, 1);
      check("model_block_cx", cur.cx, 104);
`ifdef COLOR_CENTROID_BBOX_EN
      check("block_xmin", BBOX_XMIN, 100);
      check("block_xmax", BBOX_XMAX, 109);
      check("block_ymin", BBOX_YMIN, 50);
      check("block_ymax", BBOX_YMAX, 59);
`endif

      // No matching pixel: the result still arrives after the full latency.
      for (int i = 0; i < 6; i++) pix(i * 7, i, 0, 2, 2);
      pix(639, 479, 0, 0, 0);
      wait_rv("empty");
      check("empty_count", PIXEL_COUNT, 0);
      check("empty_cx", CENTROID_X, 0);
      check("empty_det", DETECTED, 0);

      // Inclusive window edges; the frame-end pixel itself matches.
      set_win(10, 20, 5, 40, 3, 7);
      pix(1, 1, 10, 5, 3);
      pix(2, 1, 20, 40, 7);
      pix(3, 1, 9, 20, 5);
      pix(4, 1, 21, 20, 5);
      pix(5, 1, 15, 4, 5);
      pix(6, 1, 15, 41, 5);
      pix(7, 1, 15, 20, 2);
      pix(8, 1, 15, 20, 8);
      pix(639, 100, 15, 0, 0);
      pix(100, 479, 0, 20, 5);
      pix(639, 479, 15, 20, 5);
      wait_rv("edges");
      check("edges_count", PIXEL_COUNT, 3);
      check("edges_cx", CENTROID_X, 214);
      check("edges_cy", CENTROID_Y, 160);
      check("model_edges_cnt", cur.cnt, 3);

      // Inverted red window: nothing matches.
      set_win(20, 10, 0, 63, 0, 31);
      pix(3, 3, 15, 2, 2);
      pix(4, 3, 10, 2, 2);
      pix(5, 3, 20, 2, 2);
      pix(639, 479, 15, 2, 2);
      wait_rv("inverted");
      check("inverted_count", PIXEL_COUNT, 0);

      // Two frame ends 10 cycles apart: the second frame is dropped.
      set_win(25, 31, 0, 5, 0, 5);
      for (int row = 300; row < 304; row++)
         for (int col = 200; col < 205; col++) pix(col, row, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      for (int i = 0; i < 4; i++) pix(10 + i, 10, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      wait_rv("drop");
      check("drop_count", PIXEL_COUNT, 20);
      check("drop_cx", CENTROID_X, 202);
      check("drop_cy", CENTROID_Y, 301);

      // 15 matches (below threshold), then 16 including an out-of-range column.
      for (int col = 0; col < 15; col++) pix(col, 5, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      wait_rv("det15");
      check("det15_count", PIXEL_COUNT, 15);
      check("det15_det", DETECTED, 0);
      check("det15_cx", CENTROID_X, 7);
      for (int col = 0; col < 15; col++) pix(col, 5, 28, 2, 2);
      pix(1000, 5, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      wait_rv("det16");
      check("det16_det", DETECTED, 1);
      check("det16_cx", CENTROID_X, 69);

      // Reset during the Y division: no result, and the outputs clear.
      for (int col = 0; col < 16; col++) pix(300 + col, 200, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      while (cyc < acc_t + 40) @(negedge CLK);
      do_reset();
      repeat (80) @(negedge CLK);
      check("abort_count", PIXEL_COUNT, 0);
      check("abort_busy", BUSY, 0);

      // A clean frame after the abort.
      for (int col = 0; col < 16; col++) pix(300 + col, 200, 28, 2, 2);
      pix(639, 479, 0, 0, 0);
      wait_rv("post");
      check("post_cx", CENTROID_X, 307);
      check("post_cy", CENTROID_Y, 200);

      repeat (5) @(negedge CLK);
      check("drops_model", drops_seen, drops_exp);
      check("drops_once", drops_seen, 1);
      check("pending_empty", pend.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
